control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
 - clk  in  1  single clock, rising edge.
 - rst  in  1  asynchronous, active-low reset.
 - run  in  1  level; starts execution from IDLE.
 - instr  in  16  instruction word from instruction memory (opcode [15:12], address [4:0]).
 - zf  in  1  zero flag from ALU.
 - cw  out  8  control word: [7] branch request, [6] pc inc, [5] ir load, [4] dm we, [3:1] alu sel, [0] acc load.
 - pc_load  out  1  pc load, already qualified by branch condition.
 - ir_out  out  16  instruction register.
 - state  out  3  current FSM state encoding.
 - halted  out  1  high in HALT.
 - illegal  out  1  sticky flag: an undefined opcode was executed.
 - instr_cnt  out  16  count of retired instructions.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of instr_cnt.

Function
REQ-003 The FSM SHALL have states IDLE=0, FETCH=1, EXEC=2, NEXT=3, HALT=4.
REQ-004 IDLE SHALL go to FETCH on the first rising edge where run=1, and SHALL otherwise stay in IDLE.
REQ-005 FETCH SHALL assert cw[5], SHALL capture instr into ir_out on that edge, and SHALL go to EXEC.
REQ-006 EXEC SHALL drive cw from ir_out[15:12] according to the opcode table, and SHALL go to NEXT, or to HALT for HLT.
REQ-007 Opcode table (cw[7], cw[4], cw[3:1], cw[0]):
 - 0 NOP: 0, 0, 000, 0.
 - 1 LDA: 0, 0, 000 (pass in2), 1.
 - 2 STA: 0, 1, 000, 0.
 - 3 ADD: 0, 0, 001, 1.
 - 4 SUB: 0, 0, 010, 1.
 - 5 AND: 0, 0, 011, 1.
 - 6 OR: 0, 0, 100, 1.
 - 7 XOR: 0, 0, 101, 1.
 - 8 NOT: 0, 0, 110, 1.
 - 9 JZ: 1, 0, 000, 0.
 - A JMP: 1, 0, 000, 0.
 - F HLT: 0, 0, 000, 0.
 - B–E: treated as NOP and set illegal.
REQ-008 At the end of EXEC the block SHALL register taken = (JMP) OR (JZ AND zf).
REQ-009 NEXT SHALL assert pc_load=1 with cw[6]=0 if taken, otherwise cw[6]=1 with pc_load=0; NEXT SHALL go to FETCH.
REQ-010 cw SHALL be 8'h00 in every state except FETCH, EXEC and NEXT as specified above.
REQ-011 pc_load and cw[6] SHALL never both be high.
REQ-012 instr_cnt SHALL increment by one on each NEXT→FETCH transition and on EXEC→HALT, and SHALL wrap from all-ones to zero.
REQ-013 HALT SHALL be absorbing: halted=1, cw=0, and run is ignored; only reset exits HALT.
REQ-014 run deasserting mid-program SHALL have no effect; once started, the sequencer SHALL continue to HLT.
REQ-015 Each instruction SHALL take exactly 3 cycles (FETCH, EXEC, NEXT); HLT SHALL take 2 cycles to reach HALT.

Reset
REQ-016 When rst=0, regardless of clk, the block SHALL set state=IDLE, ir_out=0, cw=0, pc_load=0, halted=0, illegal=0, instr_cnt=0 and taken=0.
REQ-017 Reset asserted mid-instruction SHALL abort that instruction with no dm write or acc load pending after release.
REQ-018 After reset release the block SHALL remain in IDLE until run=1.

Configuration
REQ-019 With macro SEQ_SINGLE_STEP_EN defined:
 - a 1-bit input step SHALL exist.
 - NEXT SHALL go to a wait state STEP=5 (cw=0), which advances to FETCH on the first cycle with step=1.
REQ-020 Without SEQ_SINGLE_STEP_EN, the step port and the STEP state SHALL not exist, and NEXT SHALL go directly to FETCH.

Structure
REQ-021 A shared package seq_pkg SHALL hold:
 - the state encodings,
 - the 4-bit opcode constants,
 - the ALU select constants (000–110),
 - the cw bit-index constants.
REQ-022 Opcode→cw decode SHALL be a combinational sub-module seq_decoder (input opcode; outputs cw_exec, is_branch, is_jz, is_halt, is_illegal); the FSM, IR, taken flag and counter SHALL stay in control_sequencer.

Verification
REQ-023 Reset, then run=1, with instr=16'h3005 → cw[5]=1 in cycle 1, cw=8'b0000_0011 in cycle 2, cw=8'h40 in cycle 3, and instr_cnt=1 afterwards.
REQ-024 instr=16'h9010 with zf=1 during EXEC → pc_load=1 and cw[6]=0 in NEXT; repeated with zf=0 → pc_load=0 and cw[6]=1.
REQ-025 instr=16'h2007 → cw[4]=1 only in EXEC, and the sequencer returns to FETCH.
REQ-026 instr=16'hC000 → illegal=1 and remains 1 over the next 10 NOP instructions; instr=16'hF000 → halted=1, and run toggling keeps state=4.
REQ-027 rst pulled low during EXEC of an ADD → cw=0 immediately and all outputs at reset values; with instr_cnt preloaded via 65535 NOPs, the next NOP → instr_cnt=0.
REQ-028 With SEQ_SINGLE_STEP_EN defined: after NEXT, state=5 holds for 20 cycles with step=0, and a one-cycle step=1 pulse → FETCH next cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared encodings for the control sequencer: states, opcodes, ALU selects, cw bits.
// SEQ_SINGLE_STEP_EN adds the STEP wait state.
package seq_pkg;

`ifdef SEQ_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_HALT  = 3'd4,
        ST_STEP  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;
`endif

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_NOT  = 3'b110;

    localparam int CW_BR     = 7;
    localparam int CW_PC_INC = 6;
    localparam int CW_IR_LD  = 5;
    localparam int CW_DM_WE  = 4;
    localparam int CW_ALU_HI = 3;
    localparam int CW_ALU_LO = 1;
    localparam int CW_ACC_LD = 0;

    function automatic logic [7:0] mk_cw(
        input logic       br,
        input logic       dm,
        input logic [2:0] alu,
        input logic       acc
    );
        logic [7:0] c;
        c = '0;
        c[CW_BR] = br;
        c[CW_DM_WE] = dm;
        c[CW_ALU_HI:CW_ALU_LO] = alu;
        c[CW_ACC_LD] = acc;
        return c;
    endfunction

endpackage

// File: rtl/seq_decoder.sv
// Combinational opcode decoder producing the EXEC-phase control word.
// Undefined opcodes decode as NOP and raise is_illegal.
module seq_decoder
    import seq_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [7:0] cw_exec,
    output logic       is_branch,
    output logic       is_jz,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        cw_exec    = '0;
        is_branch  = 1'b0;
        is_jz      = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        unique case (opcode)
            OP_NOP: cw_exec = '0;
            OP_LDA: cw_exec = mk_cw(1'b0, 1'b0, ALU_PASS, 1'b1);
            OP_STA: cw_exec = mk_cw(1'b0, 1'b1, ALU_PASS, 1'b0);
            OP_ADD: cw_exec = mk_cw(1'b0, 1'b0, ALU_ADD, 1'b1);
            OP_SUB: cw_exec = mk_cw(1'b0, 1'b0, ALU_SUB, 1'b1);
            OP_AND: cw_exec = mk_cw(1'b0, 1'b0, ALU_AND, 1'b1);
            OP_OR:  cw_exec = mk_cw(1'b0, 1'b0, ALU_OR, 1'b1);
            OP_XOR: cw_exec = mk_cw(1'b0, 1'b0, ALU_XOR, 1'b1);
            OP_NOT: cw_exec = mk_cw(1'b0, 1'b0, ALU_NOT, 1'b1);
            OP_JZ: begin
                cw_exec   = mk_cw(1'b1, 1'b0, ALU_PASS, 1'b0);
                is_branch = 1'b1;
                is_jz     = 1'b1;
            end
            OP_JMP: begin
                cw_exec   = mk_cw(1'b1, 1'b0, ALU_PASS, 1'b0);
                is_branch = 1'b1;
            end
            OP_HLT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// FETCH/EXEC/NEXT control sequencer with IR, branch-taken flag and retire counter.
// Optional SEQ_SINGLE_STEP_EN inserts a STEP wait state after NEXT.
module control_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [15:0]      instr,
    input  logic             zf,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic [7:0]       cw,
    output logic             pc_load,
    output logic [15:0]      ir_out,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [7:0] CW_FETCH = 8'(1 << CW_IR_LD);
    localparam logic [7:0] CW_INC   = 8'(1 << CW_PC_INC);

    state_t            r_state;
    logic [7:0]        r_cw;
    logic [15:0]       r_ir;
    logic              r_taken;
    logic              r_halted;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_cnt;

    logic [3:0]        w_opcode;
    logic [7:0]        w_cw_exec;
    logic              w_is_branch;
    logic              w_is_jz;
    logic              w_is_halt;
    logic              w_is_illegal;
    logic              w_taken;

    // In FETCH decode the incoming word so EXEC's cw is ready on entry
    assign w_opcode = (r_state == ST_FETCH) ? instr[15:12] : r_ir[15:12];
    assign w_taken  = w_is_branch & (~w_is_jz | zf);

    seq_decoder u_dec (
        .opcode     (w_opcode),
        .cw_exec    (w_cw_exec),
        .is_branch  (w_is_branch),
        .is_jz      (w_is_jz),
        .is_halt    (w_is_halt),
        .is_illegal (w_is_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cw      <= '0;
            r_ir      <= '0;
            r_taken   <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state <= ST_FETCH;
                        r_cw    <= CW_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_ir    <= instr;
                    r_state <= ST_EXEC;
                    r_cw    <= w_cw_exec;
                end
                ST_EXEC: begin
                    r_illegal <= r_illegal | w_is_illegal;
                    if (w_is_halt) begin
                        r_state  <= ST_HALT;
                        r_cw     <= '0;
                        r_taken  <= 1'b0;
                        r_halted <= 1'b1;
                        r_cnt    <= r_cnt + CNT_W'(1);
                    end else begin
                        r_state <= ST_NEXT;
                        r_taken <= w_taken;
                        r_cw    <= w_taken ? 8'h00 : CW_INC;
                    end
                end
                ST_NEXT: begin
                    r_taken <= 1'b0;
                    r_cnt   <= r_cnt + CNT_W'(1);
`ifdef SEQ_SINGLE_STEP_EN
                    r_state <= ST_STEP;
                    r_cw    <= '0;
`else
                    r_state <= ST_FETCH;
                    r_cw    <= CW_FETCH;
`endif
                end
`ifdef SEQ_SINGLE_STEP_EN
                ST_STEP: begin
                    if (step) begin
                        r_state <= ST_FETCH;
                        r_cw    <= CW_FETCH;
                    end
                end
`endif
                ST_HALT: begin
                    r_cw <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cw    <= '0;
                    r_taken <= 1'b0;
                end
            endcase
        end
    end

    assign cw        = r_cw;
    assign pc_load   = r_taken;
    assign ir_out    = r_ir;
    assign state     = r_state;
    assign halted    = r_halted;
    assign illegal   = r_illegal;
    assign instr_cnt = r_cnt;

endmodule
